// File: rtl/lin_slave_frame_buf.sv
// LIN slave frame buffer: writable response RAM with two independent
// burst-read channels (1..4 words per request), registered outputs.
module lin_slave_frame_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  input  logic              rd_req_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [1:0]        rd_len_a,
  output logic              busy_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_valid_a,
  output logic              rd_last_a,
  output logic              rd_err_a,
  input  logic              rd_req_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [1:0]        rd_len_b,
  output logic              busy_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_valid_b,
  output logic              rd_last_b,
  output logic              rd_err_b
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so beat addresses past 2**ADDR_W-1 compare as out of range.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  typedef enum logic {IDLE, BURST} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              req  [2];
  logic [ADDR_W-1:0] addr [2];
  logic [1:0]        len  [2];

  assign req[0]  = rd_req_a;
  assign req[1]  = rd_req_b;
  assign addr[0] = rd_addr_a;
  assign addr[1] = rd_addr_b;
  assign len[0]  = rd_len_a;
  assign len[1]  = rd_len_b;

  always_ff @(posedge clk) begin
    if (wr_en && ({1'b0, wr_addr} < LIMIT))
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset)
      wr_err <= 1'b0;
    else
      wr_err <= wr_en && ({1'b0, wr_addr} >= LIMIT);
  end

  for (genvar c = 0; c < 2; c++) begin : g_ch
    state_t            state;
    logic [ADDR_W:0]   cur;
    logic [1:0]        remain;
    logic [ADDR_W:0]   beat_addr;
    logic              beat_bad;
    logic              beat_final;
    logic              busy;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              last;
    logic              err;

    // The request cycle itself issues the first beat, giving one-cycle latency;
    // BURST only covers the beats that follow it.
    always_comb begin
      beat_addr  = (state == IDLE) ? {1'b0, addr[c]} : cur;
      beat_bad   = (beat_addr >= LIMIT);
      beat_final = (state == IDLE) ? (len[c] == 2'd0) : (remain == 2'd0);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state  <= IDLE;
        cur    <= '0;
        remain <= '0;
        busy   <= 1'b0;
        data   <= '0;
        valid  <= 1'b0;
        last   <= 1'b0;
        err    <= 1'b0;
      end else if (state == BURST || req[c]) begin
        valid <= 1'b1;
        err   <= beat_bad;
        last  <= beat_bad || beat_final;
        data  <= beat_bad ? '0 : mem[beat_addr[IDX_W-1:0]];
        if (beat_bad || beat_final) begin
          state  <= IDLE;
          busy   <= 1'b0;
          cur    <= '0;
          remain <= '0;
        end else begin
          state  <= BURST;
          busy   <= 1'b1;
          cur    <= beat_addr + (ADDR_W+1)'(1);
          remain <= (state == IDLE) ? (len[c] - 2'd1) : (remain - 2'd1);
        end
      end else begin
        busy  <= 1'b0;
        data  <= '0;
        valid <= 1'b0;
        last  <= 1'b0;
        err   <= 1'b0;
      end
    end
  end

  assign busy_a     = g_ch[0].busy;
  assign rd_data_a  = g_ch[0].data;
  assign rd_valid_a = g_ch[0].valid;
  assign rd_last_a  = g_ch[0].last;
  assign rd_err_a   = g_ch[0].err;
  assign busy_b     = g_ch[1].busy;
  assign rd_data_b  = g_ch[1].data;
  assign rd_valid_b = g_ch[1].valid;
  assign rd_last_b  = g_ch[1].last;
  assign rd_err_b   = g_ch[1].err;

endmodule

// File: tb/tb_lin_slave_frame_buf.sv
// Scoreboard bench for lin_slave_frame_buf: expected beats are queued per
// channel when a request is driven and compared as the DUT emits them.
module tb_lin_slave_frame_buf;

  localparam int DW = 32;
  localparam int DP = 16;
  localparam int AW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          err;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_err;
  logic          rd_req_a, rd_req_b;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [1:0]    rd_len_a, rd_len_b;
  logic          busy_a, busy_b;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          rd_valid_a, rd_valid_b;
  logic          rd_last_a, rd_last_b;
  logic          rd_err_a, rd_err_b;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en = 1'b0;

  logic [DW-1:0] model [DP];
  beat_t q_a [$];
  beat_t q_b [$];

  lin_slave_frame_buf #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
    .rd_req_a(rd_req_a), .rd_addr_a(rd_addr_a), .rd_len_a(rd_len_a),
    .busy_a(busy_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
    .rd_last_a(rd_last_a), .rd_err_a(rd_err_a),
    .rd_req_b(rd_req_b), .rd_addr_b(rd_addr_b), .rd_len_b(rd_len_b),
    .busy_b(busy_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
    .rd_last_b(rd_last_b), .rd_err_b(rd_err_b)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int ch, input int a, input int l);
    beat_t b;
    for (int i = 0; i <= l; i++) begin
      if (a + i >= DP) begin
        b.data = '0; b.last = 1'b1; b.err = 1'b1;
      end else begin
        b.data = model[a + i]; b.last = (i == l); b.err = 1'b0;
      end
      if (ch == 0) q_a.push_back(b); else q_b.push_back(b);
      if (b.err) break;
    end
  endtask

  task automatic mon(input int ch, input logic v, input logic l, input logic e,
                     input logic bz, input logic [DW-1:0] d);
    beat_t exp;
    string nm;
    nm = (ch == 0) ? "A" : "B";
    if (v) begin
      if ((ch == 0 && q_a.size() == 0) || (ch == 1 && q_b.size() == 0)) begin
        check_eq({nm, "_unexpected_beat"}, 1, 0);
      end else begin
        exp = (ch == 0) ? q_a.pop_front() : q_b.pop_front();
        check_eq({nm, "_data"}, d, exp.data);
        check_eq({nm, "_last"}, l, exp.last);
        check_eq({nm, "_err"}, e, exp.err);
        check_eq({nm, "_busy_beat"}, bz, !exp.last);
      end
    end else begin
      check_eq({nm, "_idle_data"}, d, 0);
      check_eq({nm, "_idle_flags"}, {l, e, bz}, 0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, rd_valid_a, rd_last_a, rd_err_a, busy_a, rd_data_a);
      mon(1, rd_valid_b, rd_last_b, rd_err_b, busy_b, rd_data_b);
    end
  end

  task automatic write(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    if (a < DP) model[a] = d;
  endtask

  task automatic req_a(input int a, input int l);
    rd_req_a = 1'b1; rd_addr_a = AW'(a); rd_len_a = 2'(l);
    push_exp(0, a, l);
  endtask

  task automatic req_b(input int a, input int l);
    rd_req_b = 1'b1; rd_addr_b = AW'(a); rd_len_b = 2'(l);
    push_exp(1, a, l);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) tick();
    check_eq("drain_timeout", 64'(q_a.size() + q_b.size()), 0);
    tick();
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_req_a = 1'b0; rd_addr_a = '0; rd_len_a = '0;
    rd_req_b = 1'b0; rd_addr_b = '0; rd_len_b = '0;
    repeat (3) tick();
    reset = 1'b0;
    check_eq("reset_outputs",
             {wr_err, busy_a, rd_valid_a, rd_last_a, rd_err_a,
              busy_b, rd_valid_b, rd_last_b, rd_err_b}, 0);
    check_eq("reset_data", {rd_data_a, rd_data_b}, 0);
    mon_en = 1'b1;

    write(0, 32'h20111025);
    write(1, 32'h78910012);
    write(2, 32'h0011102F);
    write(3, 32'hCDEF7891);
    write(14, 32'h1400BEEF);
    write(15, 32'h15C0FFEE);
    check_eq("wr_err_inrange", wr_err, 0);

    // Four-word burst on A
    req_a(0, 3); tick(); rd_req_a = 1'b0;
    drain();

    // Simultaneous A and B on the same address
    req_a(1, 0); req_b(1, 1); tick(); rd_req_a = 1'b0; rd_req_b = 1'b0;
    drain();

    // Overrun past DEPTH-1 terminates with an error beat
    req_b(14, 3); tick(); rd_req_b = 1'b0;
    drain();
    check_eq("B_busy_after_err", busy_b, 0);

    // Address beyond DEPTH at the start of the burst
    req_a(200, 2); tick(); rd_req_a = 1'b0;
    drain();

    // Read/write collision returns the old word
    wr_en = 1'b1; wr_addr = 8'h01; wr_data = 32'hAAAA5555;
    req_a(1, 0);
    tick();
    wr_en = 1'b0; rd_req_a = 1'b0;
    model[1] = 32'hAAAA5555;
    drain();
    req_a(1, 0); tick(); rd_req_a = 1'b0;
    drain();

    // Out-of-range write
    write(32, 32'hDEADDEAD);
    check_eq("wr_err_pulse", wr_err, 1);
    tick();
    check_eq("wr_err_clear", wr_err, 0);
    req_a(0, 0); tick(); rd_req_a = 1'b0;
    drain();

    // Request while busy is ignored
    req_a(0, 3); tick();
    rd_req_a = 1'b1; rd_addr_a = 8'd2; rd_len_a = 2'd0;
    tick(); rd_req_a = 1'b0;
    drain();

    // Back-to-back: new request in the last-beat cycle
    req_b(2, 1); tick(); rd_req_b = 1'b0;
    tick();
    req_b(3, 0); tick(); rd_req_b = 1'b0;
    drain();

    // Reset during the second beat of a four-word burst
    req_a(0, 3); tick(); rd_req_a = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    q_a.delete();
    reset = 1'b0;
    check_eq("reset_mid_burst", {busy_a, rd_valid_a, rd_last_a, rd_err_a}, 0);
    check_eq("reset_mid_data", rd_data_a, 0);
    tick();
    req_a(2, 1); tick(); rd_req_a = 1'b0;
    drain();

    check_eq("queues_empty", 64'(q_a.size() + q_b.size()), 0);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
